// File: rtl/audio_arb_pkg.sv
// audio_arb_pkg: shared states, widths and tone amplitude for the audio output arbiter
package audio_arb_pkg;
    localparam int HALF_PERIOD_W = 19;
    localparam int SAMPLES_W = 16;
    localparam logic signed [31:0] AMPL = 32'sd2094967295;
    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
endpackage

// File: rtl/square_tone_gen.sv
// square_tone_gen: square wave of +/-AMPL toggling every half_period+1 cycles, silent for half_period 0
module square_tone_gen
    import audio_arb_pkg::*;
(
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load,
    input  logic [HALF_PERIOD_W-1:0] half_period,
    output logic signed [31:0]       sample
);
    logic [HALF_PERIOD_W-1:0] hp_q, cnt;
    logic pol;
    // latch the period and restart positive on load, then toggle polarity at each half period
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            hp_q <= '0;
            cnt  <= '0;
            pol  <= 1'b1;
        end else if (load) begin
            hp_q <= half_period;
            cnt  <= '0;
            pol  <= 1'b1;
        end else if (enable) begin
            cnt <= (cnt == hp_q) ? '0 : cnt + 1'b1;
            pol <= (cnt == hp_q) ? ~pol : pol;
        end
    end
    assign sample = (hp_q == '0) ? '0 : (pol ? AMPL : -AMPL);
endmodule

// File: rtl/audio_out_arbiter.sv
// audio_out_arbiter: grants one tone requester at a time, streams its tone then a silence gap;
// define AUDIO_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of lowest-index priority
module audio_out_arbiter
    import audio_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int GAP_SAMPLES = 480
) (
    input  logic                             CLOCK_50,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ*HALF_PERIOD_W-1:0] req_half_period,
    input  logic [NUM_REQ*SAMPLES_W-1:0]     req_samples,
    input  logic                             audio_out_allowed,
    output logic [NUM_REQ-1:0]               grant,
    output logic [NUM_REQ-1:0]               done,
    output logic                             busy,
    output logic signed [31:0]               left_channel_audio_out,
    output logic signed [31:0]               right_channel_audio_out,
    output logic                             write_audio_out
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = $clog2(GAP_SAMPLES + 1);
    localparam int CNT_W = (GAP_W > SAMPLES_W) ? GAP_W : SAMPLES_W;

    state_t state;
    logic [CNT_W-1:0] cnt;
    logic [SAMPLES_W-1:0] samples_q, win_samples;
    logic [HALF_PERIOD_W-1:0] win_hp;
    logic [IDX_W-1:0] win;
    logic start;
    logic signed [31:0] tone;

    assign start = (state == IDLE) && (req != '0);

`ifdef AUDIO_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr, off;
    logic [IDX_W:0] base, sum;
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0] rot;
    // rotate requests so the search begins just past the last winner
    always_comb begin
        base = {1'b0, ptr} + 1'b1;
        dbl  = {req, req};
        rot  = dbl[base +: NUM_REQ];
        off  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (rot[i]) off = IDX_W'(i);
        sum  = base + {1'b0, off};
        win  = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : IDX_W'(sum);
    end
    // remember the last granted index
    always_ff @(posedge CLOCK_50) begin
        if (!reset) ptr <= '0;
        else if (start) ptr <= win;
    end
`else
    // fixed priority: lowest requesting index wins
    always_comb begin
        win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) win = IDX_W'(i);
    end
`endif

    // select the winner's tone parameters
    always_comb begin
        win_hp      = '0;
        win_samples = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (win == IDX_W'(i)) begin
                win_hp      = req_half_period[i*HALF_PERIOD_W +: HALF_PERIOD_W];
                win_samples = req_samples[i*SAMPLES_W +: SAMPLES_W];
            end
    end

    square_tone_gen u_tone (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .enable      (state == PLAY),
        .load        (start),
        .half_period (win_hp),
        .sample      (tone)
    );

    // grant, count tone samples, then count gap samples; zero-length tones go straight to the gap
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state     <= IDLE;
            grant     <= '0;
            done      <= '0;
            cnt       <= '0;
            samples_q <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (start) begin
                    grant     <= NUM_REQ'(1) << win;
                    samples_q <= win_samples;
                    cnt       <= '0;
                    state     <= (win_samples == '0) ? GAP : PLAY;
                    done      <= (win_samples == '0) ? NUM_REQ'(1) << win : '0;
                end
                PLAY: if (audio_out_allowed) begin
                    if (CNT_W'(samples_q) == cnt + 1'b1) begin
                        state <= GAP;
                        cnt   <= '0;
                        done  <= grant;
                    end else cnt <= cnt + 1'b1;
                end
                GAP: if (audio_out_allowed) begin
                    if (cnt == CNT_W'(GAP_SAMPLES - 1)) begin
                        state <= IDLE;
                        grant <= '0;
                        cnt   <= '0;
                    end else cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                    = (state != IDLE);
    assign write_audio_out         = busy && audio_out_allowed;
    assign left_channel_audio_out  = (state == PLAY) ? tone : '0;
    assign right_channel_audio_out = left_channel_audio_out;
endmodule

// File: tb/tb_audio_out_arbiter.sv
// tb_audio_out_arbiter: directed checks of grant, tone writes, gap writes, backpressure and reset
module tb_audio_out_arbiter;
    localparam logic signed [31:0] A = 32'sd2094967295;

    logic CLOCK_50 = 1'b0;
    logic reset = 1'b0;
    logic audio_out_allowed = 1'b0;
    logic [2:0] req = '0;
    logic [56:0] req_half_period = '0;
    logic [47:0] req_samples = '0;
    logic [2:0] grant, done;
    logic busy, write_audio_out;
    logic signed [31:0] left_channel_audio_out, right_channel_audio_out;
    int total = 0;
    int bad = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    audio_out_arbiter dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .req                     (req),
        .req_half_period         (req_half_period),
        .req_samples             (req_samples),
        .audio_out_allowed       (audio_out_allowed),
        .grant                   (grant),
        .done                    (done),
        .busy                    (busy),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .write_audio_out         (write_audio_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input int i, input int hp, input int s);
        req_half_period[19*i +: 19] = 19'(hp);
        req_samples[16*i +: 16] = 16'(s);
    endtask

    function automatic logic [31:0] model(input int hp, input int k);
        if (hp == 0) return 32'd0;
        return ((k / (hp + 1)) % 2 == 0) ? A : -A;
    endfunction

    task automatic tone(input logic [2:0] g, input int hp, input int s, input bit tog);
        int tw = 0, gw = 0, dn = 0, cyc = 0, bt = 0, bg = 0, sw = 0;
        bit seen = 0;
        @(negedge CLOCK_50);
        check("grant", grant, g);
        check("busy_on", busy, 1);
        req = req & ~g;
        while (busy && cyc < 3000) begin
            if (done != 0) begin
                dn++;
                seen = 1;
                check("done_bit", done, g);
            end
            if (write_audio_out && !audio_out_allowed) sw++;
            if (write_audio_out) begin
                if (!seen) begin
                    tw++;
                    if (left_channel_audio_out !== model(hp, cyc)) bt++;
                end else begin
                    gw++;
                    if (left_channel_audio_out !== 0) bg++;
                end
                if (right_channel_audio_out !== left_channel_audio_out) bt++;
            end
            if (tog) audio_out_allowed = ~audio_out_allowed;
            @(negedge CLOCK_50);
            cyc++;
        end
        check("tone_writes", tw, s);
        check("gap_writes", gw, 480);
        check("done_count", dn, 1);
        check("tone_vals", bt, 0);
        check("gap_vals", bg, 0);
        check("stall_writes", sw, 0);
        check("grant_off", grant, 0);
        if (!tog) check("cycles", cyc, s + 480);
        audio_out_allowed = 1'b1;
    endtask

    initial begin
        audio_out_allowed = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_grant", grant, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_write", write_audio_out, 0);
        check("rst_left", left_channel_audio_out, 0);
        check("rst_right", right_channel_audio_out, 0);
        reset = 1'b1;

        cfg(0, 3000, 4);
        req = 3'b001;
        tone(3'b001, 3000, 4, 0);

        cfg(1, 1, 6);
        cfg(2, 2, 5);
        req = 3'b110;
        tone(3'b010, 1, 6, 0);
        tone(3'b100, 2, 5, 0);

        cfg(0, 3000, 8);
        req = 3'b001;
        tone(3'b001, 3000, 8, 1);

        cfg(0, 3000, 0);
        req = 3'b001;
        tone(3'b001, 3000, 0, 0);

        cfg(0, 0, 4);
        req = 3'b001;
        tone(3'b001, 0, 4, 0);

        cfg(0, 3000, 20);
        req = 3'b001;
        @(negedge CLOCK_50);
        check("mid_grant", grant, 3'b001);
        req = 3'b000;
        check("mid_write1", write_audio_out, 1);
        @(negedge CLOCK_50);
        check("mid_write2", write_audio_out, 1);
        reset = 1'b0;
        @(negedge CLOCK_50);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_write", write_audio_out, 0);
        check("mid_rst_left", left_channel_audio_out, 0);
        reset = 1'b1;
        cfg(0, 3000, 4);
        req = 3'b001;
        tone(3'b001, 3000, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
